// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 instruction-fetch stage.
// Consumed by fetch_pc_reg and fetch_stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // ADD XZR,XZR,XZR: architecturally a no-op, used to fill empty IF/ID slots
  localparam logic [31:0] BUBBLE_INSTR  = 32'h8b1f03ff;
  localparam logic [31:0] HALT_SENTINEL = 32'h00000000;
  localparam logic [63:0] PC_RESET      = 64'h0;
  localparam int unsigned PC_STEP       = 4;

endpackage

// File: rtl/fetch_pc_reg.sv
// N-bit program counter with async active-high reset, parallel load and
// +4 increment enable. Load has priority over increment; neither holds.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         inc,
  output logic [N-1:0] pc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= N'(PC_RESET);
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + N'(PC_STEP);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 IF stage: PC, ROM addressing, IF/ID register and BOOT/RUN/HALT FSM.
// Optional perf counters (fetch_cnt, stall_cnt) exist when FETCH_PERF_CNT_EN is defined.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int N            = 64,
  parameter bit HALT_ON_ZERO = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         PCSrc_F,
  input  logic [N-1:0] PCBranch_F,
  input  logic         stall_F,
  input  logic         flush_D,
  output logic [5:0]   imem_addr,
  input  logic [31:0]  imem_q,
  output logic [31:0]  instr_D,
  output logic [N-1:0] pc_D,
  output logic         valid_D,
  output logic         halted,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]  fetch_cnt,
  output logic [31:0]  stall_cnt,
`endif
  output fetch_state_t state_dbg
);

  // Flow control: there is no ready back-pressure. valid_D marks that
  // instr_D/pc_D hold a real instruction; stall_F freezes PC and IF/ID,
  // flush_D or a taken redirect overwrites IF/ID with a bubble.

  fetch_state_t state;
  logic [N-1:0] pc;
  logic [N-1:0] branch_tgt;
  logic         in_run;
  logic         sentinel;
  logic         pc_inc;
  logic         load_real;
  logic [1:0]   unused_tgt_lsbs;

  // Redirect targets are word aligned; the low two bits are dropped.
  assign branch_tgt      = {PCBranch_F[N-1:2], 2'b00};
  assign unused_tgt_lsbs = PCBranch_F[1:0];

  assign in_run    = (state == RUN);
  assign sentinel  = HALT_ON_ZERO && (imem_q == HALT_SENTINEL);
  assign pc_inc    = in_run && !stall_F && !sentinel;
  assign load_real = !PCSrc_F && !flush_D && !stall_F && in_run && !sentinel;

  assign imem_addr = pc[7:2];
  assign state_dbg = state;

  fetch_pc_reg #(.N(N)) u_pc_reg (
    .clk      (clk),
    .rst      (reset),
    .load     (PCSrc_F),
    .load_val (branch_tgt),
    .inc      (pc_inc),
    .pc       (pc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_D <= BUBBLE_INSTR;
      pc_D    <= N'(PC_RESET);
      valid_D <= 1'b0;
    end else if (PCSrc_F || flush_D) begin
      instr_D <= BUBBLE_INSTR;
      pc_D    <= pc;
      valid_D <= 1'b0;
    end else if (stall_F) begin
      instr_D <= instr_D;
      pc_D    <= pc_D;
      valid_D <= valid_D;
    end else if (load_real) begin
      instr_D <= imem_q;
      pc_D    <= pc;
      valid_D <= 1'b1;
    end else begin
      instr_D <= BUBBLE_INSTR;
      pc_D    <= pc;
      valid_D <= 1'b0;
    end
  end

  // BOOT spends one cycle letting the ROM output settle after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= BOOT;
      halted <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state  <= RUN;
          halted <= 1'b0;
        end
        RUN: begin
          if (sentinel && !PCSrc_F && !stall_F) begin
            state  <= HALT;
            halted <= 1'b1;
          end
        end
        HALT: begin
          if (PCSrc_F) begin
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= BOOT;
          halted <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_cnt <= 32'd0;
      stall_cnt <= 32'd0;
    end else begin
      if (load_real && (fetch_cnt != 32'hFFFFFFFF)) begin
        fetch_cnt <= fetch_cnt + 32'd1;
      end
      if (stall_F && in_run && (stall_cnt != 32'hFFFFFFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage with a 64-word ROM model.
// Perf-counter checks are compiled in when FETCH_PERF_CNT_EN is defined.
module tb_fetch_stage;

  localparam int N = 64;
  localparam logic [31:0] BUB = 32'h8b1f03ff;

  typedef struct {
    logic         pcsrc;
    logic [N-1:0] br;
    logic         stall;
    logic         flush;
    logic         e_valid;
    logic [N-1:0] e_pc;
    logic [31:0]  e_instr;
    logic [5:0]   e_addr;
    logic         e_halt;
  } vec_t;

  logic         clk;
  logic         reset;
  logic         PCSrc_F;
  logic [N-1:0] PCBranch_F;
  logic         stall_F;
  logic         flush_D;
  logic [5:0]   imem_addr;
  logic [31:0]  imem_q;
  logic [31:0]  instr_D;
  logic [N-1:0] pc_D;
  logic         valid_D;
  logic         halted;
  logic [1:0]   state_dbg;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]  fetch_cnt;
  logic [31:0]  stall_cnt;
`endif

  logic [31:0] rom [64];
  vec_t        vecs[$];
  int          checks = 0;
  int          errors = 0;

  fetch_stage #(.N(N), .HALT_ON_ZERO(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .PCSrc_F    (PCSrc_F),
    .PCBranch_F (PCBranch_F),
    .stall_F    (stall_F),
    .flush_D    (flush_D),
    .imem_addr  (imem_addr),
    .imem_q     (imem_q),
    .instr_D    (instr_D),
    .pc_D       (pc_D),
    .valid_D    (valid_D),
    .halted     (halted),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt  (fetch_cnt),
    .stall_cnt  (stall_cnt),
`endif
    .state_dbg  (state_dbg)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_q = rom[imem_addr];

  function automatic logic [31:0] w(input int i);
    if (i == 0) return 32'h8b1f03e2;
    if (i == 1) return 32'h8b1f03e3;
    if (i == 2) return 32'h8b1f03e6;
    if (i < 13) return 32'h8b1f0300 | 32'(i);
    return 32'h0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic pcsrc, input logic [N-1:0] br, input logic stall,
                     input logic flush, input logic e_valid, input logic [N-1:0] e_pc,
                     input logic [31:0] e_instr, input logic [5:0] e_addr, input logic e_halt);
    vec_t v;
    v.pcsrc = pcsrc; v.br = br; v.stall = stall; v.flush = flush;
    v.e_valid = e_valid; v.e_pc = e_pc; v.e_instr = e_instr;
    v.e_addr = e_addr; v.e_halt = e_halt;
    vecs.push_back(v);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " valid_D"}, 64'(valid_D), 64'd0);
    chk({tag, " pc_D"}, 64'(pc_D), 64'd0);
    chk({tag, " instr_D"}, 64'(instr_D), 64'(BUB));
    chk({tag, " imem_addr"}, 64'(imem_addr), 64'd0);
    chk({tag, " halted"}, 64'(halted), 64'd0);
`ifdef FETCH_PERF_CNT_EN
    chk({tag, " fetch_cnt"}, 64'(fetch_cnt), 64'd0);
    chk({tag, " stall_cnt"}, 64'(stall_cnt), 64'd0);
`endif
  endtask

  // driver: apply one vector across one edge, compare just after it
  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      PCSrc_F    = vecs[i].pcsrc;
      PCBranch_F = vecs[i].br;
      stall_F    = vecs[i].stall;
      flush_D    = vecs[i].flush;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d valid_D", i), 64'(valid_D), 64'(vecs[i].e_valid));
      chk($sformatf("v%0d pc_D", i), 64'(pc_D), 64'(vecs[i].e_pc));
      chk($sformatf("v%0d instr_D", i), 64'(instr_D), 64'(vecs[i].e_instr));
      chk($sformatf("v%0d imem_addr", i), 64'(imem_addr), 64'(vecs[i].e_addr));
      chk($sformatf("v%0d halted", i), 64'(halted), 64'(vecs[i].e_halt));
    end
    PCSrc_F = 1'b0; PCBranch_F = '0; stall_F = 1'b0; flush_D = 1'b0;
  endtask

  initial begin
    int a_end, b1_end, b2_end;
    for (int i = 0; i < 64; i++) rom[i] = w(i);

    // Segment A: boot, stream, stall, branch, halt, resume up to PC=0x18
    add(0, 0, 0, 0, 0, 64'h00, BUB,   6'd0,  0);
    add(0, 0, 0, 0, 1, 64'h00, w(0),  6'd1,  0);
    add(0, 0, 0, 0, 1, 64'h04, w(1),  6'd2,  0);
    add(0, 0, 0, 0, 1, 64'h08, w(2),  6'd3,  0);
    add(0, 0, 0, 0, 1, 64'h0c, w(3),  6'd4,  0);
    add(0, 0, 1, 0, 1, 64'h0c, w(3),  6'd4,  0);
    add(0, 0, 1, 0, 1, 64'h0c, w(3),  6'd4,  0);
    add(0, 0, 0, 0, 1, 64'h10, w(4),  6'd5,  0);
    add(0, 0, 0, 0, 1, 64'h14, w(5),  6'd6,  0);
    add(0, 0, 0, 0, 1, 64'h18, w(6),  6'd7,  0);
    add(0, 0, 0, 0, 1, 64'h1c, w(7),  6'd8,  0);
    add(1, 64'h26, 0, 0, 0, 64'h20, BUB, 6'd9, 0);
    add(0, 0, 0, 0, 1, 64'h24, w(9),  6'd10, 0);
    add(0, 0, 0, 0, 1, 64'h28, w(10), 6'd11, 0);
    add(0, 0, 0, 0, 1, 64'h2c, w(11), 6'd12, 0);
    add(0, 0, 0, 0, 1, 64'h30, w(12), 6'd13, 0);
    add(0, 0, 0, 0, 0, 64'h34, BUB,   6'd13, 1);
    for (int i = 0; i < 10; i++) add(0, 0, (i == 4), 0, 0, 64'h34, BUB, 6'd13, 1);
    add(1, 64'h0, 0, 0, 0, 64'h34, BUB, 6'd0, 0);
    add(0, 0, 0, 0, 1, 64'h00, w(0),  6'd1,  0);
    add(0, 0, 0, 0, 1, 64'h04, w(1),  6'd2,  0);
    add(0, 0, 0, 0, 1, 64'h08, w(2),  6'd3,  0);
    add(0, 0, 0, 0, 1, 64'h0c, w(3),  6'd4,  0);
    add(0, 0, 0, 0, 1, 64'h10, w(4),  6'd5,  0);
    add(0, 0, 0, 0, 1, 64'h14, w(5),  6'd6,  0);
    a_end = vecs.size() - 1;
    // Segment B1: reboot after mid-run reset, then flush_D with stall_F
    add(0, 0, 0, 0, 0, 64'h00, BUB,   6'd0,  0);
    add(0, 0, 0, 0, 1, 64'h00, w(0),  6'd1,  0);
    add(0, 0, 0, 0, 1, 64'h04, w(1),  6'd2,  0);
    add(0, 0, 1, 1, 0, 64'h08, BUB,   6'd2,  0);
    b1_end = vecs.size() - 1;
    // Segment B2: flush alone, stall+redirect, sentinel at 0x40, aliasing at 0x104
    add(0, 0, 0, 1, 0, 64'h08, BUB,   6'd3,  0);
    add(0, 0, 0, 0, 1, 64'h0c, w(3),  6'd4,  0);
    add(1, 64'h41, 1, 0, 0, 64'h10, BUB, 6'd16, 0);
    add(0, 0, 0, 0, 0, 64'h40, BUB,   6'd16, 1);
    add(1, 64'h104, 0, 0, 0, 64'h40, BUB, 6'd1, 0);
    add(0, 0, 0, 0, 1, 64'h104, w(1), 6'd2,  0);
    b2_end = vecs.size() - 1;

    reset = 1'b1; PCSrc_F = 1'b0; PCBranch_F = '0; stall_F = 1'b0; flush_D = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_reset_state("boot");

    run_vecs(0, a_end);

    // Asynchronous reset mid-run at PC=0x18: takes effect before any edge
    #2;
    reset = 1'b1;
    #1;
    check_reset_state("async_rst");
    @(negedge clk);
    reset = 1'b0;

    run_vecs(a_end + 1, b1_end);
`ifdef FETCH_PERF_CNT_EN
    chk("cnt fetch after flush+stall", 64'(fetch_cnt), 64'd2);
    chk("cnt stall after flush+stall", 64'(stall_cnt), 64'd1);
`endif
    run_vecs(b1_end + 1, b2_end);
`ifdef FETCH_PERF_CNT_EN
    chk("cnt fetch final", 64'(fetch_cnt), 64'd4);
    chk("cnt stall final", 64'(stall_cnt), 64'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the LEGv8 pipelined datapath.
- Owns the PC register and drives the word address into the 64-word instruction ROM.
- Captures the returned word and its PC into the IF/ID pipeline register.
- Handles branch redirect, stall, flush, and a halt-on-sentinel FSM.

Parameters:
- N, 64, datapath/PC width in bits.
- HALT_ON_ZERO, 1, when 1 a fetched word equal to 32'h00000000 halts fetch.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- PCSrc_F  in  1  branch/redirect taken this cycle
- PCBranch_F  in  N  redirect target byte address
- stall_F  in  1  hold PC and IF/ID contents
- flush_D  in  1  replace IF/ID contents with bubble
- imem_addr  out  6  ROM word index = PC[7:2]
- imem_q  in  32  ROM read data, combinational from imem_addr
- instr_D  out  32  IF/ID instruction
- pc_D  out  N  IF/ID PC of instr_D
- valid_D  out  1  IF/ID entry holds a real instruction
- halted  out  1  FSM in HALT

Behaviour:
- Reset (async, active-high):
  - PC=0, state=BOOT, instr_D=BUBBLE_INSTR, pc_D=0, valid_D=0, halted=0.
  - Asserting reset mid-operation discards all state immediately.
- PC next, in priority order:
  - PCSrc_F: {PCBranch_F[N-1:2],2'b00}; bits [1:0] of the target are ignored.
  - else stall_F, or state in {BOOT, HALT}: hold PC.
  - else PC+4, mod 2^N.
- imem_addr = PC[7:2]. PCs of 0x100 and above alias into the ROM.
- IF/ID update, in priority order:
  - PCSrc_F or flush_D: bubble (instr_D=BUBBLE_INSTR, valid_D=0, pc_D=PC).
  - else stall_F: hold all.
  - else state=RUN and not sentinel: instr_D=imem_q, pc_D=PC, valid_D=1.
  - else: bubble.
- FSM states: BOOT, RUN, HALT.
  - BOOT -> RUN unconditionally on the first clock after reset release. This gives one cycle for the ROM output to settle.
  - RUN -> HALT when HALT_ON_ZERO=1, imem_q==0, PCSrc_F=0 and stall_F=0. PC freezes on the sentinel address and no bubble-free entry is produced.
  - RUN -> HALT when PCSrc_F=1 is not taken; redirect wins.
  - HALT -> RUN only on PCSrc_F=1; PC loads the target that same edge.
  - stall_F has no effect on HALT.
- halted = (state==HALT), registered.
- Latency: instruction at PC appears on instr_D one edge after PC presents it.
- Simultaneous stall_F and PCSrc_F: redirect wins and IF/ID is bubbled.
- Simultaneous flush_D and stall_F: PC holds and IF/ID is bubbled.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs fetch_cnt[31:0] and stall_cnt[31:0], both reset to 0.
  - fetch_cnt increments on each edge where valid_D is loaded with 1.
  - stall_cnt increments on each edge with stall_F=1 and state=RUN.
  - Both saturate at 32'hFFFFFFFF.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- fetch_pkg holds:
  - fetch_state_t enum {BOOT, RUN, HALT}.
  - BUBBLE_INSTR = 32'h8b1f03ff (ADD XZR,XZR,XZR).
  - HALT_SENTINEL = 32'h00000000.
  - PC_RESET = 0.
- One sub-module, fetch_pc_reg: N-bit async-reset register with enable and load.

Test Plan:
- Reset then release; the bench ROM model holds 8b1f03e2, 8b1f03e3, 8b1f03e6 at words 0-2.
  - Cycle 1 (BOOT): valid_D=0, imem_addr=0.
  - Next edges: instr_D=8b1f03e2/pc_D=0, then 8b1f03e3/pc_D=4, then 8b1f03e6/pc_D=8, each with valid_D=1.
- stall_F=1 for 2 cycles at PC=0x10: PC and imem_addr=4 hold, and instr_D/pc_D are unchanged. Resume yields pc_D=0x10 then 0x14.
- PCSrc_F=1, PCBranch_F=0x26 at PC=0x20:
  - Next edge: PC=0x24, instr_D=8b1f03ff, valid_D=0.
  - Following edge: pc_D=0x24, valid_D=1.
- Words 13 and up are 0. Fetch reaches PC=0x34: state HALT, halted=1, PC stays 0x34, valid_D=0 for 10 cycles. Then PCSrc_F=1, PCBranch_F=0 gives RUN with pc_D=0 valid one edge later.
- Assert reset mid-run at PC=0x18: PC, pc_D, valid_D and halted go to 0 without waiting for a clock edge. With FETCH_PERF_CNT_EN defined, fetch_cnt=0 too.
- Assert flush_D and stall_F together: PC holds, IF/ID is bubbled (valid_D=0). With FETCH_PERF_CNT_EN defined, stall_cnt increments by 1.
